// File: rtl/aes128_round_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides.
// The key schedule runs alongside the rounds, so a block takes 12 cycles from accept to accept.
module aes128_round_sequencer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_key,
  input  logic [127:0] plaintext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [3:0]   rnd;
  logic [127:0] next_key;
  logic [127:0] sub_shifted;
  logic [127:0] round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // State byte 4*c+r sits at row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = SBOX[s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  // One key-schedule step: RotWord/SubWord/Rcon on the last word, then a running XOR.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {SBOX[k[23:16]] ^ rc, SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    next_key    = key_step(key_reg, rcon(rnd));
    sub_shifted = sub_shift(state_reg);
    round_out   = (rnd == 4'd10) ? (sub_shifted ^ next_key)
                                 : (mix_columns(sub_shifted) ^ next_key);
  end

  assign in_ready  = rst_n && (fsm == IDLE);
  assign round_idx = rnd;

  // rnd doubles as round_idx, so it is cleared on leaving RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      key_reg    <= '0;
      rnd        <= '0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state_reg <= plaintext ^ cipher_key;
            key_reg   <= cipher_key;
            rnd       <= 4'd1;
            busy      <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          state_reg <= round_out;
          key_reg   <= next_key;
          if (rnd == 4'd10) begin
            rnd        <= 4'd0;
            out_valid  <= 1'b1;
            ciphertext <= round_out;
            fsm        <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            ciphertext <= '0;
            busy       <= 1'b0;
            fsm        <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Bench for aes128_round_sequencer: byte-level AES model with a cycle-accurate handshake model,
// checked every cycle, plus FIPS-197 known-answer vectors.
module tb_aes128_round_sequencer;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_key;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sb [256];
  bit           m_busy = 1'b0;
  int           m_k = 0;
  logic [127:0] m_exp = '0;
  bit           e_ov;
  int           acc_q [$];
  logic [127:0] got_q [$];

  aes128_round_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cipher_key (cipher_key),
    .plaintext  (plaintext),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from first principles: GF(2^8) inverse (a^254) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   k [16];
    logic [7:0]   t [16];
    logic [7:0]   w [4];
    logic [7:0]   a0, a1, a2, a3;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127 - 8 * i -: 8];
      s[i] = pt[127 - 8 * i -: 8] ^ k[i];
    end
    for (int rd = 1; rd <= 10; rd++) begin
      w[0] = sb[k[13]] ^ rc;
      w[1] = sb[k[14]];
      w[2] = sb[k[15]];
      w[3] = sb[k[12]];
      for (int i = 0; i < 4; i++) k[i] ^= w[i];
      for (int i = 4; i < 16; i++) k[i] ^= k[i - 4];
      rc = xt(rc);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4 * c + r] = sb[s[4 * ((c + r) % 4) + r]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (rd < 10) begin
          s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= k[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  // Handshake model: m_k counts rounds since acceptance; result is presented after the tenth.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_exp  = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_k    = 0;
        m_exp  = aes_model(cipher_key, plaintext);
      end
    end else if (m_k < 10) begin
      m_k++;
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    e_ov = m_busy && (m_k == 10);
    check_output("in_ready", 128'(in_ready), 128'(rst_n && !m_busy));
    check_output("busy", 128'(busy), 128'(m_busy));
    check_output("round_idx", 128'(round_idx), (m_busy && m_k < 10) ? 128'(m_k + 1) : 128'd0);
    check_output("out_valid", 128'(out_valid), 128'(e_ov));
    check_output("ciphertext", ciphertext, e_ov ? m_exp : 128'd0);
    if (in_valid && in_ready) acc_q.push_back(cyc);
    if (out_valid && out_ready) got_q.push_back(ciphertext);
  end

  task automatic apply_stimulus(input logic [127:0] k, input logic [127:0] p);
    bit was_ready;
    int waited;
    cipher_key = k;
    plaintext  = p;
    in_valid   = 1'b1;
    for (waited = 0; waited < 50; waited++) begin
      was_ready = in_ready;
      @(posedge clk);
      #1;
      if (was_ready) break;
    end
    in_valid = 1'b0;
    check_output("accept_timeout", 128'(waited < 50), 128'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic wait_for(input bit on_got, input int target);
    int n;
    n = 0;
    while (((on_got ? got_q.size() : acc_q.size()) < target) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output(on_got ? "got_count" : "acc_count",
                 128'(on_got ? got_q.size() : acc_q.size()), 128'(target));
  endtask

  initial begin
    int lat;
    int n0;
    int g0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));

    rst_n      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    cipher_key = '0;
    plaintext  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_in_ready", 128'(in_ready), 128'd0);
    check_output("reset_ct", ciphertext, 128'd0);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_ready", 128'(in_ready), 128'd1);

    check_output("model_vec1", aes_model(K1, P1), C1);
    check_output("model_vec2", aes_model(K2, P2), C2);
    check_output("model_vec0", aes_model('0, '0), C0);

    // Appendix C.1 vector: latency and result
    apply_stimulus(K1, P1);
    wait_valid(lat);
    check_output("latency_vec1", 128'(lat), 128'd10);
    check_output("ct_vec1", ciphertext, C1);
    @(posedge clk);
    #1;
    check_output("ready_after_drain", 128'(in_ready), 128'd1);

    // Appendix B vector: round_idx walk, input changes mid-run ignored
    apply_stimulus(K2, P2);
    for (int k = 0; k <= 10; k++) begin
      check_output("round_walk", 128'(round_idx), (k < 10) ? 128'(k + 1) : 128'd0);
      if (k == 4) begin
        cipher_key = ~K2;
        plaintext  = ~P2;
      end
      if (k < 10) begin
        @(posedge clk);
        #1;
      end
    end
    check_output("ct_vec2", ciphertext, C2);
    @(posedge clk);
    #1;

    // Back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    apply_stimulus('0, '0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      check_output("hold_valid", 128'(out_valid), 128'd1);
      check_output("hold_ct", ciphertext, C0);
      check_output("hold_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1;
    end
    g0 = got_q.size();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("single_transfer", 128'(got_q.size()), 128'(g0 + 1));
    check_output("held_ct_value", got_q[got_q.size() - 1], C0);
    check_output("drained_valid", 128'(out_valid), 128'd0);

    // Back-to-back with in_valid held high
    n0 = acc_q.size();
    g0 = got_q.size();
    cipher_key = K1;
    plaintext  = P1;
    in_valid   = 1'b1;
    wait_for(1'b0, n0 + 1);
    cipher_key = K2;
    plaintext  = P2;
    wait_for(1'b0, n0 + 2);
    cipher_key = '0;
    plaintext  = '0;
    wait_for(1'b0, n0 + 3);
    repeat (3) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    plaintext = P1;
    wait_for(1'b1, g0 + 3);
    if (acc_q.size() >= n0 + 3 && got_q.size() >= g0 + 3) begin
      check_output("b2b_gap1", 128'(acc_q[n0 + 1] - acc_q[n0]), 128'd12);
      check_output("b2b_gap2", 128'(acc_q[n0 + 2] - acc_q[n0 + 1]), 128'd12);
      check_output("b2b_ct1", got_q[g0], C1);
      check_output("b2b_ct2", got_q[g0 + 1], C2);
      check_output("b2b_ct3", got_q[g0 + 2], C0);
    end
    @(posedge clk);
    #1;

    // Abort at round 5, then run a fresh block
    g0 = got_q.size();
    apply_stimulus(K1, P1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_output("abort_round", 128'(round_idx), 128'd5);
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_output("abort_busy", 128'(busy), 128'd0);
    check_output("abort_valid", 128'(out_valid), 128'd0);
    check_output("abort_round0", 128'(round_idx), 128'd0);
    check_output("abort_ready", 128'(in_ready), 128'd0);
    rst_n = 1'b1;
    #1;
    check_output("abort_ready_after", 128'(in_ready), 128'd1);
    apply_stimulus(K1, P1);
    wait_valid(lat);
    check_output("latency_after_abort", 128'(lat), 128'd10);
    check_output("ct_after_abort", ciphertext, C1);
    @(posedge clk);
    #1;
    check_output("abort_transfers", 128'(got_q.size()), 128'(g0 + 1));

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
